multdiv_issue_ctrl: RTL

- Initiator side of the multicycle mult/div handshake: the pipeline-facing controller that launches operations on the multiplier/divider units and collects their results.
- Latches operands and destination, pulses ctrl_MULT/ctrl_DIV for one cycle, stalls the pipeline, waits for unit ready, then issues a one-cycle register-file writeback.
- On unit exception, redirects the writeback to rstatus.
- Sits between execute stage and the mult/div units.

---
 rtl/multdiv_issue_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: initiator side of the multicycle mult/div handshake.
// Latches an execute-stage request, pulses the selected unit's start line for
// one cycle, stalls the pipeline while the unit works, then emits a one-cycle
// register-file writeback (redirected to rstatus on a unit exception).
//
// Optional build macro: MULTDIV_TIMEOUT_EN adds a WAIT-state watchdog that
// forces an exception writeback after TIMEOUT_CYCLES and sets a sticky flag.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   issue_mult, issue_div        execute-stage request (divide wins if both)
//   operand_A, operand_B, rd     operands and destination register
//   ctrl_MULT, ctrl_DIV          one-cycle start pulses to the units
//   mult_or_div                  0 = multiply, 1 = divide, held per operation
//   data_operandA/B              latched operands, stable per operation
//   unit_result/exception/ready  selected unit response
//   stall                        freeze upstream pipeline
//   wb_en, wb_rd, wb_data        one-cycle register-file writeback
//   wb_exception                 writeback carries an exception code
//   timeout                      sticky watchdog flag (0 without the macro)
module multdiv_issue_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned RSTATUS_ADDR   = 30,
  parameter int unsigned MULT_EXC_CODE  = 4,
  parameter int unsigned DIV_EXC_CODE   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_mult,
  input  logic              issue_div,
  input  logic [DATA_W-1:0] operand_A,
  input  logic [DATA_W-1:0] operand_B,
  input  logic [ADDR_W-1:0] rd,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic              mult_or_div,
  output logic [DATA_W-1:0] data_operandA,
  output logic [DATA_W-1:0] data_operandB,
  input  logic [DATA_W-1:0] unit_result,
  input  logic              unit_exception,
  input  logic              unit_ready,
  output logic              stall,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exception,
  output logic              timeout
);

  localparam int unsigned WDOG_W = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              div_q, div_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              exc_q, exc_d;
  logic              issue;

`ifdef MULTDIV_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              to_q, to_d;
`endif

  assign issue = issue_mult | issue_div;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      wdog_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
`ifdef MULTDIV_TIMEOUT_EN
      wdog_q  <= wdog_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rd_d         = rd_q;
    div_d        = div_q;
    res_d        = res_q;
    exc_d        = exc_q;
`ifdef MULTDIV_TIMEOUT_EN
    wdog_d       = wdog_q;
    to_d         = to_q;
`endif
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    stall        = 1'b0;
    wb_en        = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    wb_exception = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = issue;
      end
      S_START: begin
        // unit_ready is deliberately ignored here: it may still be high from
        // the previous operation.
        stall     = 1'b1;
        ctrl_MULT = ~div_q;
        ctrl_DIV  = div_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (unit_ready) begin
          res_d   = unit_result;
          exc_d   = unit_exception;
          state_d = S_WB;
`ifdef MULTDIV_TIMEOUT_EN
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted WAIT cycle with no response: fault the operation.
          res_d   = '0;
          exc_d   = 1'b1;
          to_d    = 1'b1;
          state_d = S_WB;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
`endif
        end
      end
      S_WB: begin
        if (exc_q) begin
          wb_en        = 1'b1;
          wb_rd        = ADDR_W'(RSTATUS_ADDR);
          wb_data      = div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
          wb_exception = 1'b1;
        end else if (rd_q != '0) begin
          // r0 is hardwired zero, so a clean result to it is dropped.
          wb_en   = 1'b1;
          wb_rd   = rd_q;
          wb_data = res_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept a new request in IDLE or WB; WB acceptance gives back-to-back issue.
    if ((state_q == S_IDLE || state_q == S_WB) && issue) begin
      opa_d   = operand_A;
      opb_d   = operand_B;
      rd_d    = rd;
      div_d   = issue_div;
      state_d = S_START;
`ifdef MULTDIV_TIMEOUT_EN
      wdog_d  = '0;
`endif
    end
  end

  assign mult_or_div   = div_q;
  assign data_operandA = opa_q;
  assign data_operandB = opb_q;

`ifdef MULTDIV_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
